instr_loader: RTL

- Writer side of instruction memory: the block the fetch/decode path reads from.
- Accepts a little-endian byte stream over a valid/ready handshake and packs it into 32-bit instruction words.
- Writes the words to consecutive instruction-memory word addresses starting at 0.
- Flags any word whose opcode field the control decoder does not support. Used at boot/test to load programs before the core is released.

---
 rtl/instr_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// instr_loader : packs a little-endian byte stream into 32-bit instruction
//                words and writes them to instruction memory from address 0.
// Revision     : 1.0
// ============================================================================
module instr_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32   // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  err_opcode,
  output logic                  err_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [1:0]            r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_err_opcode;
  logic                  r_err_overflow;

  logic                  w_in_load;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_full;
  logic                  w_store;
  logic                  w_complete;
  logic                  w_opcode_ok;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_in_load = (r_state == ST_LOAD);
  assign w_start   = start && !w_in_load;
  assign w_accept  = byte_valid && w_in_load;
  // Memory is full exactly when the count reaches 2^ADDR_WIDTH (MSB set).
  assign w_full    = r_word_count[ADDR_WIDTH];
  assign w_store   = w_accept && !w_full;

  // Shift register is cleared after each word, so unreceived bytes read as zero.
  assign w_word = r_shift |
                  ({{(DATA_WIDTH-8){1'b0}}, byte_data} << {r_byte_cnt, 3'b000});

  assign w_complete = w_store && ((r_byte_cnt == 2'd3) || byte_last);

  always_comb begin
    w_opcode_ok = 1'b0;
    case (w_word[6:0])
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b1100011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: w_opcode_ok = 1'b1;
      default:                            w_opcode_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD;
      ST_LOAD: if (w_accept && byte_last) w_next = ST_DONE;
      ST_DONE: if (start) w_next = ST_LOAD;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr          <= '0;
      r_byte_cnt     <= 2'd0;
      r_shift        <= '0;
      r_word_count   <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_err_opcode   <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start) begin
        r_ptr          <= '0;
        r_byte_cnt     <= 2'd0;
        r_shift        <= '0;
        r_word_count   <= '0;
        r_err_opcode   <= 1'b0;
        r_err_overflow <= 1'b0;
      end else if (w_complete) begin
        r_mem_we     <= 1'b1;
        r_mem_addr   <= r_ptr;
        r_mem_wdata  <= w_word;
        r_ptr        <= r_ptr + 1'b1;
        r_word_count <= r_word_count + 1'b1;
        r_shift      <= '0;
        r_byte_cnt   <= 2'd0;
        if (!w_opcode_ok) begin
          r_err_opcode <= 1'b1;
        end
      end else if (w_store) begin
        r_shift    <= w_word;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end else if (w_accept) begin
        // Memory full: byte dropped, stream keeps draining toward byte_last.
        r_err_overflow <= 1'b1;
      end
    end
  end

  assign byte_ready   = w_in_load;
  assign busy         = w_in_load;
  assign done         = (r_state == ST_DONE);
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign word_count   = r_word_count;
  assign err_opcode   = r_err_opcode;
  assign err_overflow = r_err_overflow;

endmodule
`default_nettype wire
